// File: rtl/pixel_unpacker_if.sv
// Packed-pixel AXI4-Stream word bus between the pixel packer and the unpacker.
interface pixel_unpacker_if;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast;
  logic        tuser;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface

// File: rtl/pixel_unpacker.sv
// Unpacks 32-bit words carrying 24-bit RGB pixels (4 pixels per 3 words) into
// one pixel per handshake with raster position, SOF/EOL markers and framing checks.
module pixel_unpacker #(
  parameter int X_SIZE = 640,
  parameter int Y_SIZE = 480
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  pixel_unpacker_if.slave        in_stream,
  output logic [7:0]             r,
  output logic [7:0]             g,
  output logic [7:0]             b,
  output logic                   valid,
  input  logic                   ready,
  output logic                   sof,
  output logic                   eol,
  output logic [9:0]             x,
  output logic [8:0]             y,
  output logic                   sof_err,
  output logic                   eol_err,
  output logic [15:0]            frame_count
);

  localparam logic [9:0] X_LAST = 10'(X_SIZE - 1);
  localparam logic [8:0] Y_LAST = 9'(Y_SIZE - 1);

  // W0..W2 accept a word each; W3 drains the three held bytes as a pixel.
  typedef enum logic [1:0] {W0, W1, W2, W3} phase_t;

  phase_t      phase, phase_next;
  logic [7:0]  hold0, hold1, hold2, hold0_next, hold1_next, hold2_next;
  logic [9:0]  nx, nx_next;          // position the next loaded pixel gets
  logic [8:0]  ny, ny_next;
  logic [7:0]  r_next, g_next, b_next;
  logic [9:0]  x_next;
  logic [8:0]  y_next;
  logic        sof_next, eol_next, valid_next, sof_err_next, eol_err_next;
  logic [15:0] frame_count_next;

  logic        can_emit, accept, exp_user, exp_last, resync, line_cut, load;
  logic [7:0]  b0, b1, b2, b3, pix_r, pix_g, pix_b;
  logic [9:0]  px;
  logic [8:0]  py;
  logic        unused_keep;

  // All bytes are treated as valid, so tkeep carries no information.
  assign unused_keep = ^in_stream.tkeep;

  assign b0 = in_stream.tdata[7:0];
  assign b1 = in_stream.tdata[15:8];
  assign b2 = in_stream.tdata[23:16];
  assign b3 = in_stream.tdata[31:24];

  assign can_emit        = !valid || ready;
  assign in_stream.tready = aresetn && can_emit && (phase != W3);
  assign accept          = in_stream.tvalid && in_stream.tready;

  // tuser belongs on the W0 word that starts a frame; tlast on the W2 word
  // whose trailing W3 pixel closes the line.
  assign exp_user = (phase == W0) && (nx == 10'd0) && (ny == 9'd0);
  assign exp_last = (phase == W2) && (nx == X_LAST - 10'd1);
  assign resync   = accept && in_stream.tuser && !exp_user;
  assign line_cut = accept && in_stream.tlast && !exp_last && !resync;

  // Next-state: phase, held bytes, output register, raster position, error pulses
  always_comb begin
    phase_next       = phase;
    hold0_next       = hold0;
    hold1_next       = hold1;
    hold2_next       = hold2;
    nx_next          = nx;
    ny_next          = ny;
    frame_count_next = frame_count;
    r_next           = r;
    g_next           = g;
    b_next           = b;
    x_next           = x;
    y_next           = y;
    sof_next         = sof;
    eol_next         = eol;
    valid_next       = valid && !ready;
    sof_err_next     = 1'b0;
    eol_err_next     = 1'b0;
    load             = 1'b0;
    pix_r            = 8'd0;
    pix_g            = 8'd0;
    pix_b            = 8'd0;
    px               = nx;
    py               = ny;

    if (accept) begin
      load         = 1'b1;
      sof_err_next = (in_stream.tuser != exp_user);
      // A resynced word counts as a frame-start W0 word, where tlast never belongs.
      eol_err_next = resync ? in_stream.tlast : (in_stream.tlast != exp_last);
      if (resync) begin
        {pix_r, pix_g, pix_b} = {b0, b1, b2};
        hold0_next = b3;
        hold1_next = 8'd0;
        hold2_next = 8'd0;
        px         = 10'd0;
        py         = 9'd0;
        phase_next = W1;
      end else begin
        case (phase)
          W0: begin
            {pix_r, pix_g, pix_b} = {b0, b1, b2};
            hold0_next = b3;
            phase_next = W1;
          end
          W1: begin
            {pix_r, pix_g, pix_b} = {hold0, b0, b1};
            hold0_next = b2;
            hold1_next = b3;
            phase_next = W2;
          end
          W2: begin
            {pix_r, pix_g, pix_b} = {hold0, hold1, b0};
            hold0_next = b1;
            hold1_next = b2;
            hold2_next = b3;
            phase_next = W3;
          end
          default: ;
        endcase
      end
    end else if ((phase == W3) && can_emit) begin
      load                  = 1'b1;
      {pix_r, pix_g, pix_b} = {hold0, hold1, hold2};
      phase_next            = W0;
    end

    if (load) begin
      r_next     = pix_r;
      g_next     = pix_g;
      b_next     = pix_b;
      x_next     = px;
      y_next     = py;
      sof_next   = (px == 10'd0) && (py == 9'd0);
      eol_next   = (px == X_LAST);
      valid_next = 1'b1;
      // An early tlast ends the line after this pixel just like reaching X_LAST.
      if (line_cut || (px == X_LAST)) begin
        nx_next = 10'd0;
        if (py == Y_LAST) begin
          ny_next          = 9'd0;
          frame_count_next = frame_count + 16'd1;
        end else begin
          ny_next = py + 9'd1;
        end
      end else begin
        nx_next = px + 10'd1;
        ny_next = py;
      end
      // Leftover bytes of a cut line are dropped (including a pending W3 pixel).
      if (line_cut) begin
        phase_next = W0;
        hold0_next = 8'd0;
        hold1_next = 8'd0;
        hold2_next = 8'd0;
      end
    end
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      phase       <= W0;
      hold0       <= 8'd0;
      hold1       <= 8'd0;
      hold2       <= 8'd0;
      nx          <= 10'd0;
      ny          <= 9'd0;
      frame_count <= 16'd0;
      r           <= 8'd0;
      g           <= 8'd0;
      b           <= 8'd0;
      x           <= 10'd0;
      y           <= 9'd0;
      sof         <= 1'b0;
      eol         <= 1'b0;
      valid       <= 1'b0;
      sof_err     <= 1'b0;
      eol_err     <= 1'b0;
    end else begin
      phase       <= phase_next;
      hold0       <= hold0_next;
      hold1       <= hold1_next;
      hold2       <= hold2_next;
      nx          <= nx_next;
      ny          <= ny_next;
      frame_count <= frame_count_next;
      r           <= r_next;
      g           <= g_next;
      b           <= b_next;
      x           <= x_next;
      y           <= y_next;
      sof         <= sof_next;
      eol         <= eol_next;
      valid       <= valid_next;
      sof_err     <= sof_err_next;
      eol_err     <= eol_err_next;
    end
  end

endmodule
